// File: rtl/vs_acc_fsm.sv
// Serial hex accumulator: parses "+/-<hex>CR LF" frames, updates ACC and streams a ROM message.
// Optional clear command ('C' CR LF) is enabled by defining VS_CLEAR_CMD_EN.
module vs_acc_fsm #(
   parameter int unsigned OP_DIGITS  = 7,
   parameter int unsigned ACC_DIGITS = 21,
   parameter int unsigned ADDR_W     = 7
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RX_DATA_EN,
   input  logic [9:0]        RX_DATA_R,
   output logic              TX_RDY_T,
   output logic [7:0]        TX_DATA_T,
   input  logic              TX_RDY_R,
   output logic [ADDR_W-1:0] ADDR,
   input  logic [7:0]        DATA
);

   localparam int unsigned ACC_W = 4 * ACC_DIGITS;
   localparam int unsigned OP_W  = 4 * OP_DIGITS;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned DIG_W = 5;

   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      RDT  = 4'd1,
      RCR  = 4'd2,
      RLF  = 4'd3,
      TLD  = 4'd4,
      TMSG = 4'd5,
      TDT  = 4'd6,
      TCR  = 4'd7,
      TLF  = 4'd8
   } state_e;

   state_e              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [OP_W-1:0]     opnd_q, opnd_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                res_q, res_d;
   logic                sub_q, sub_d;
   logic                clr_q, clr_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   end_q, end_d;
   logic [DIG_W-1:0]    dig_q, dig_d;
   logic                tx_rdy_q, tx_rdy_d;
   logic [7:0]          tx_data_q, tx_data_d;

   // {valid, value} for an ASCII hex digit of either case
   function automatic logic [4:0] hex_dec(input logic [7:0] b);
      logic [4:0] r;
      r = '0;
      if (b >= 8'h30 && b <= 8'h39)      r = {1'b1, 4'(b - 8'h30)};
      else if (b >= 8'h41 && b <= 8'h46) r = {1'b1, 4'(b - 8'h37)};
      else if (b >= 8'h61 && b <= 8'h66) r = {1'b1, 4'(b - 8'h57)};
      return r;
   endfunction

   function automatic logic [7:0] hex_chr(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   logic [7:0]       rx_byte;
   logic [1:0]       rx_flags;
   logic [4:0]       hx;
   logic             err;
   logic [3:0]       nib;
   logic [DIG_W+1:0] sh;

   assign rx_byte  = RX_DATA_R[7:0];
   assign rx_flags = RX_DATA_R[9:8];

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      sub_d     = sub_q;
      clr_d     = clr_q;
      addr_d    = addr_q;
      end_d     = end_q;
      dig_d     = dig_q;
      tx_rdy_d  = tx_rdy_q;
      tx_data_d = tx_data_q;
      hx        = hex_dec(rx_byte);
      err       = 1'b0;
      nib       = '0;
      sh        = '0;

      case (state_q)
         IDLE: if (RX_DATA_EN) begin
            if (rx_flags != 2'b00) err = 1'b1;
            else if (rx_byte == CH_PLUS || rx_byte == CH_MINUS) begin
               sub_d   = (rx_byte == CH_MINUS);
               clr_d   = 1'b0;
               opnd_d  = '0;
               cnt_d   = '0;
               state_d = RDT;
            end
`ifdef VS_CLEAR_CMD_EN
            else if (rx_byte == 8'h43 || rx_byte == 8'h63) begin
               clr_d   = 1'b1;
               opnd_d  = '0;
               cnt_d   = '0;
               state_d = RCR;
            end
`endif
            else err = 1'b1;
         end
         RDT: if (RX_DATA_EN) begin
            if (rx_flags != 2'b00) err = 1'b1;
            else if (hx[4]) begin
               opnd_d = OP_W'({opnd_q, hx[3:0]});
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q + CNT_W'(1) == CNT_W'(OP_DIGITS)) state_d = RCR;
            end
            else if (rx_byte == CH_CR && cnt_q != '0) state_d = RLF;
            else err = 1'b1;
         end
         RCR: if (RX_DATA_EN) begin
            if (rx_flags == 2'b00 && rx_byte == CH_CR) state_d = RLF;
            else err = 1'b1;
         end
         RLF: if (RX_DATA_EN) begin
            if (rx_flags == 2'b00 && rx_byte == CH_LF) begin
               if (clr_q)      acc_d = '0;
               else if (sub_q) acc_d = acc_q - ACC_W'(opnd_q);
               else            acc_d = acc_q + ACC_W'(opnd_q);
               opnd_d  = '0;
               cnt_d   = '0;
               clr_d   = 1'b0;
               res_d   = 1'b1;
               addr_d  = ADDR_W'(8'h00);
               end_d   = ADDR_W'(8'h06);
               state_d = TLD;
            end
            else err = 1'b1;
         end
         TLD: begin
            tx_data_d = DATA;
            tx_rdy_d  = 1'b1;
            addr_d    = addr_q + ADDR_W'(1);
            state_d   = TMSG;
         end
         TMSG: if (TX_RDY_R) begin
            // addr_q already points one past the byte just taken
            if (addr_q == end_q + ADDR_W'(1)) begin
               if (res_q) begin
                  nib       = acc_q[ACC_W-1 -: 4];
                  tx_data_d = hex_chr(nib);
                  dig_d     = DIG_W'(ACC_DIGITS - 1);
                  state_d   = TDT;
               end else begin
                  tx_data_d = CH_CR;
                  state_d   = TCR;
               end
            end else begin
               tx_data_d = DATA;
               addr_d    = addr_q + ADDR_W'(1);
            end
         end
         TDT: if (TX_RDY_R) begin
            if (dig_q == '0) begin
               tx_data_d = CH_CR;
               state_d   = TCR;
            end else begin
               sh        = {dig_q - DIG_W'(1), 2'b00};
               nib       = 4'(acc_q >> sh);
               tx_data_d = hex_chr(nib);
               dig_d     = dig_q - DIG_W'(1);
            end
         end
         TCR: if (TX_RDY_R) begin
            tx_data_d = CH_LF;
            state_d   = TLF;
         end
         TLF: if (TX_RDY_R) begin
            tx_rdy_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Any receive error drops the partial frame and selects a message by the flag bits
      if (err) begin
         opnd_d  = '0;
         cnt_d   = '0;
         clr_d   = 1'b0;
         res_d   = 1'b0;
         state_d = TLD;
         case (rx_flags)
            2'b01:   begin addr_d = ADDR_W'(8'h18); end_d = ADDR_W'(8'h23); end
            2'b10:   begin addr_d = ADDR_W'(8'h24); end_d = ADDR_W'(8'h2F); end
            2'b11:   begin addr_d = ADDR_W'(8'h30); end_d = ADDR_W'(8'h46); end
            default: begin addr_d = ADDR_W'(8'h07); end_d = ADDR_W'(8'h17); end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         opnd_q    <= '0;
         cnt_q     <= '0;
         res_q     <= 1'b0;
         sub_q     <= 1'b0;
         clr_q     <= 1'b0;
         addr_q    <= '0;
         end_q     <= '0;
         dig_q     <= '0;
         tx_rdy_q  <= 1'b0;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         cnt_q     <= cnt_d;
         res_q     <= res_d;
         sub_q     <= sub_d;
         clr_q     <= clr_d;
         addr_q    <= addr_d;
         end_q     <= end_d;
         dig_q     <= dig_d;
         tx_rdy_q  <= tx_rdy_d;
         tx_data_q <= tx_data_d;
      end
   end

   assign TX_RDY_T  = tx_rdy_q;
   assign TX_DATA_T = tx_data_q;
   assign ADDR      = addr_q;

endmodule

// File: tb/tb_vs_acc_fsm.sv
// Directed bench for vs_acc_fsm: ROM model, byte-level frames, response stream checks.
module tb_vs_acc_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_DATA_EN;
   logic [9:0] RX_DATA_R;
   logic       TX_RDY_T;
   logic [7:0] TX_DATA_T;
   logic       TX_RDY_R;
   logic [6:0] ADDR;
   logic [7:0] DATA;

   int total = 0;
   int bad   = 0;
   logic [83:0] acc_m;
   string hexs = "0123456789ABCDEF";

   vs_acc_fsm #(.OP_DIGITS(7), .ACC_DIGITS(21), .ADDR_W(7)) dut (
      .CLK(CLK), .RST(RST), .RX_DATA_EN(RX_DATA_EN), .RX_DATA_R(RX_DATA_R),
      .TX_RDY_T(TX_RDY_T), .TX_DATA_T(TX_DATA_T), .TX_RDY_R(TX_RDY_R),
      .ADDR(ADDR), .DATA(DATA)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] rom_f(input int a);
      return 8'(a) ^ 8'h5A;
   endfunction

   assign DATA = rom_f(int'(ADDR));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic [1:0] fl);
      @(negedge CLK);
      RX_DATA_EN = 1'b1;
      RX_DATA_R  = {fl, b};
      @(negedge CLK);
      RX_DATA_EN = 1'b0;
      RX_DATA_R  = '0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i], 2'b00);
   endtask

   task automatic wait_rdy();
      for (int i = 0; i < 20 && TX_RDY_T !== 1'b1; i++) @(negedge CLK);
      chk("rdy_rise", 32'(TX_RDY_T), 32'd1);
   endtask

   task automatic take(input string tag, input logic [7:0] exp);
      chk({tag, "_rdy"}, 32'(TX_RDY_T), 32'd1);
      chk(tag, 32'(TX_DATA_T), 32'(exp));
      TX_RDY_R = 1'b1;
      @(negedge CLK);
      TX_RDY_R = 1'b0;
      @(negedge CLK);
   endtask

   task automatic expect_resp(input string tag, input int s, input int e, input bit res);
      wait_rdy();
      for (int a = s; a <= e; a++) take({tag, "_msg"}, rom_f(a));
      if (res)
         for (int i = 20; i >= 0; i--) take({tag, "_dig"}, hexs[acc_m[4*i +: 4]]);
      take({tag, "_cr"}, 8'h0D);
      take({tag, "_lf"}, 8'h0A);
      chk({tag, "_rdy_drop"}, 32'(TX_RDY_T), 32'd0);
      chk({tag, "_idle"}, 32'(dut.state_q), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      RST = 1'b1; RX_DATA_EN = 1'b0; RX_DATA_R = '0; TX_RDY_R = 1'b0;
      acc_m = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      chk("rst_rdy", 32'(TX_RDY_T), 32'd0);
      chk("rst_data", 32'(TX_DATA_T), 32'h00);
      chk("rst_addr", 32'(ADDR), 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'd0);

      // 7 digits fills the operand, CR then taken in RCR
      send_str("+0000005"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
      acc_m = 84'h5;
      expect_resp("add5", 0, 6, 1'b1);

      send_str("-6"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
      acc_m = {84{1'b1}};
      expect_resp("sub6", 0, 6, 1'b1);

      send_str("+12345678");
      expect_resp("toolong", 8'h07, 8'h17, 1'b0);

      send(8'h2B, 2'b01);
      expect_resp("parity", 8'h18, 8'h23, 1'b0);

      send(8'h2B, 2'b10);
      expect_resp("stop", 8'h24, 8'h2F, 1'b0);

      send(8'h2B, 2'b11);
      expect_resp("both", 8'h30, 8'h46, 1'b0);

      // ACC kept its all-ones value through the errors
      send_str("+3"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
      acc_m = 84'h2;
      expect_resp("add3", 0, 6, 1'b1);

      // lower-case digit, then reset mid-digits
      send_str("+a"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
      acc_m = 84'hC;
      wait_rdy();
      for (int a = 0; a <= 6; a++) take("rstmid_msg", rom_f(a));
      chk("rstmid_in_tdt", 32'(dut.state_q), 32'd6);
      take("rstmid_dig", 8'h30);
      take("rstmid_dig", 8'h30);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      chk("rstmid_rdy", 32'(TX_RDY_T), 32'd0);
      chk("rstmid_state", 32'(dut.state_q), 32'd0);
      chk("rstmid_data", 32'(TX_DATA_T), 32'h00);
      chk("rstmid_addr", 32'(ADDR), 32'd0);
      TX_RDY_R = 1'b1;
      @(negedge CLK);
      TX_RDY_R = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rstmid_quiet", 32'(TX_RDY_T), 32'd0);
      acc_m = '0;

      send_str("+1"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
      acc_m = 84'h1;
      expect_resp("after_rst", 0, 6, 1'b1);

      // CR with no digits; the trailing LF lands during the response and is dropped
      send_str("+"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
      expect_resp("nodig", 8'h07, 8'h17, 1'b0);

      send_str("C"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
`ifdef VS_CLEAR_CMD_EN
      acc_m = '0;
      expect_resp("clear", 0, 6, 1'b1);
`else
      expect_resp("clear_syn", 8'h07, 8'h17, 1'b0);
`endif

      send_str("+0"); send(8'h0D, 2'b00); send(8'h0A, 2'b00);
      expect_resp("add0", 0, 6, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
